// File: rtl/uart_frame_rec.sv
// Collects DEPTH bytes from a UART receiver, optionally after a sync byte, and publishes
// them atomically on frame_data with a one-cycle frame_valid strobe and inter-byte timeout.
module uart_frame_rec #(
    parameter int         DEPTH       = 4,
    parameter int         USE_SYNC    = 1,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx_done_tick,
    input  logic [7:0]                   dout,
    output logic [8*DEPTH-1:0]           frame_data,
    output logic                         frame_valid,
    output logic                         timeout_err,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   byte_cnt,
    output logic [7:0]                   last_byte
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t               state, state_n;
    logic                 rx_done_d;
    logic                 acc;
    logic                 store;
    logic [TW-1:0]        timer, timer_n;
    logic [CW-1:0]        cnt_n;
    logic [8*DEPTH-1:0]   staging, staging_n;
    logic [8*DEPTH-1:0]   frame_n;
    logic                 valid_n;
    logic                 terr_n;
    logic [7:0]           last_n;

    // Rising edge of the tick only, so a long tick is accepted exactly once.
    assign acc  = rx_done_tick & ~rx_done_d;
    assign busy = (state == COLLECT);

    // NOTE: every sequential register uses non-blocking assignment so all state updates
    // see the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rx_done_d   <= 1'b1;
            timer       <= '0;
            byte_cnt    <= '0;
            staging     <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
            last_byte   <= '0;
        end else begin
            state       <= state_n;
            rx_done_d   <= rx_done_tick;
            timer       <= timer_n;
            byte_cnt    <= cnt_n;
            staging     <= staging_n;
            frame_data  <= frame_n;
            frame_valid <= valid_n;
            timeout_err <= terr_n;
            last_byte   <= last_n;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        cnt_n     = byte_cnt;
        staging_n = staging;
        frame_n   = frame_data;
        valid_n   = 1'b0;
        terr_n    = 1'b0;
        last_n    = acc ? dout : last_byte;
        store     = acc && ((state == COLLECT) || (USE_SYNC == 0));

        if (store) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (CW'(k) == byte_cnt) staging_n[8*k +: 8] = dout;
            end
            timer_n = '0;
            if (byte_cnt == LAST_SLOT) begin
                frame_n = staging_n;
                valid_n = 1'b1;
                cnt_n   = '0;
                state_n = IDLE;
            end else begin
                cnt_n   = byte_cnt + CW'(1);
                state_n = COLLECT;
            end
        end else if (state == IDLE) begin
            if (acc && dout == SYNC_BYTE) begin
                state_n = COLLECT;
                cnt_n   = '0;
                timer_n = '0;
            end
        end else if (timer == TIMER_MAX) begin
            // Partial frame discarded; frame_data keeps the last complete frame.
            terr_n  = 1'b1;
            cnt_n   = '0;
            timer_n = '0;
            state_n = IDLE;
        end else begin
            timer_n = timer + TW'(1);
        end
    end

endmodule
